// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD port arbiter.
// Imported by the interface, the picker and the top.
package sd_arb_pkg;

    localparam int SD_LBA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_port_arbiter_if.sv
// SD-side bundle between the arbiter and the SPI interface.
// The arbiter is the master; the IO controller is the slave.
interface sd_port_arbiter_if;
    import sd_arb_pkg::*;

    logic                sd_rd;
    logic                sd_wr;
    logic [SD_LBA_W-1:0] sd_lba;
    logic [7:0]          sd_din;
    logic                sd_ack;
    logic                sd_dout_strobe;
    logic                sd_din_strobe;

    modport master (
        output sd_rd, sd_wr, sd_lba, sd_din,
        input  sd_ack, sd_dout_strobe, sd_din_strobe
    );

    modport slave (
        input  sd_rd, sd_wr, sd_lba, sd_din,
        output sd_ack, sd_dout_strobe, sd_din_strobe
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first pending index at or after rr,
// wrapping modulo NREQ.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IDXW-1:0] rr_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o
);

    logic [IDXW-1:0] cand;

    // Walk from the farthest offset down so the nearest one wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(rr_i) + k) % NREQ);
            if (pending_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sd_port_arbiter.sv
// Shares one SD emulation port between NREQ drive controllers,
// granting round-robin and demuxing ack/strobes to the winner.
module sd_port_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic                     clk_sd,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_rd,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [SD_LBA_W*NREQ-1:0] req_lba,
    input  logic [8*NREQ-1:0]        req_din,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          req_dout_strobe,
    output logic [NREQ-1:0]          req_din_strobe,
    sd_port_arbiter_if.master        sd,
    output logic [IDXW-1:0]          grant_idx,
    output logic                     busy
);

    arb_state_e          state_q;
    logic [IDXW-1:0]     grant_q;
    logic [IDXW-1:0]     rr_q;
    logic                rd_q;
    logic                wr_q;
    logic                have_q;
    logic [SD_LBA_W-1:0] lba_q;

    logic [NREQ-1:0]     pending;
    logic                pick_vld;
    logic [IDXW-1:0]     pick_idx;
    logic [IDXW-1:0]     rr_d;
    logic [SD_LBA_W-1:0] lba_a [NREQ];
    logic [7:0]          din_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lba_a[i] = req_lba[SD_LBA_W*i +: SD_LBA_W];
        assign din_a[i] = req_din[8*i +: 8];
    end

    assign pending = req_rd | req_wr;

    assign rr_d = (grant_q == IDXW'(NREQ - 1)) ? '0
                                               : grant_q + IDXW'(1);

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .pending_i (pending),
        .rr_i      (rr_q),
        .valid_o   (pick_vld),
        .idx_o     (pick_idx)
    );

    always_ff @(posedge clk_sd or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            have_q  <= 1'b0;
            lba_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        lba_q   <= lba_a[pick_idx];
                        // rd+wr together is served as a read.
                        rd_q    <= req_rd[pick_idx];
                        wr_q    <= ~req_rd[pick_idx];
                        have_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd.sd_ack) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= XFER;
                    end else if (!pending[grant_q]) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (!sd.sd_ack) begin
                        rr_q    <= rr_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ack         = '0;
        req_dout_strobe = '0;
        req_din_strobe  = '0;
        if (state_q == XFER) begin
            req_ack[grant_q]         = sd.sd_ack;
            req_dout_strobe[grant_q] = sd.sd_dout_strobe;
            req_din_strobe[grant_q]  = sd.sd_din_strobe;
        end
    end

    assign sd.sd_rd   = rd_q;
    assign sd.sd_wr   = wr_q;
    assign sd.sd_lba  = lba_q;
    assign sd.sd_din  = have_q ? din_a[grant_q] : 8'h00;
    assign grant_idx  = grant_q;
    assign busy       = (state_q != IDLE);

endmodule
